// File: rtl/ex_stage_pkg.sv
// Shared Y86 encodings, condition-code layout and the JXX/CMOVXX condition evaluator
// used by the execute stage and its ALU.
package ex_stage_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = 3'b100;

  function automatic logic cond_eval(input cc_t cc, input logic [3:0] ifun);
    logic lt;
    logic res;
    lt = cc.sf ^ cc.of;
    case (ifun)
      C_YES:   res = 1'b1;
      C_LE:    res = lt | cc.zf;
      C_L:     res = lt;
      C_E:     res = cc.zf;
      C_NE:    res = ~cc.zf;
      C_GE:    res = ~lt;
      C_G:     res = ~lt & ~cc.zf;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode->execute and execute->memory channels, each a valid/ready handshake.
// master drives the payload and valid, slave drives ready.
interface dec_ex_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       icode_i;
  logic [3:0]       ifun_i;
  logic [WIDTH-1:0] valA_i;
  logic [WIDTH-1:0] valB_i;
  logic [WIDTH-1:0] valC_i;
  logic [3:0]       dstE_i;
  logic [3:0]       dstM_i;

  modport master (output in_valid, icode_i, ifun_i, valA_i, valB_i, valC_i, dstE_i, dstM_i,
                  input  in_ready);
  modport slave  (input  in_valid, icode_i, ifun_i, valA_i, valB_i, valC_i, dstE_i, dstM_i,
                  output in_ready);
endinterface

interface ex_mem_if #(parameter int WIDTH = 32);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] valE_o;
  logic [WIDTH-1:0] valA_o;
  logic [3:0]       icode_o;
  logic [3:0]       dstE_o;
  logic [3:0]       dstM_o;
  logic             cnd_o;
  logic             err_o;

  modport master (output out_valid, valE_o, valA_o, icode_o, dstE_o, dstM_o, cnd_o, err_o,
                  input  out_ready);
  modport slave  (input  out_valid, valE_o, valA_o, icode_o, dstE_o, dstM_o, cnd_o, err_o,
                  output out_ready);
endinterface

// File: rtl/ex_stage_alu.sv
// Combinational execute ALU: valE selection, ZF/SF/OF of the result and illegal-ifun detection.
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STACK_STEP = 4
) (
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] r,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             err
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);
  localparam int MSB = WIDTH - 1;

  always_comb begin
    r   = '0;
    of  = 1'b0;
    err = 1'b0;
    case (icode)
      I_CMOVXX: begin
        if (ifun > C_G) err = 1'b1;
        else            r   = a;
      end
      I_IRMOVL:          r = c;
      I_RMMOVL, I_MRMOVL: r = b + c;
      I_OPL: begin
        case (ifun)
          A_ADD: begin
            r  = b + a;
            of = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
          end
          A_SUB: begin
            r  = b - a;
            of = (a[MSB] != b[MSB]) && (r[MSB] != b[MSB]);
          end
          A_AND:   r   = b & a;
          A_XOR:   r   = b ^ a;
          default: err = 1'b1;
        endcase
      end
      I_JXX:            err = (ifun > C_G);
      I_CALL, I_PUSHL:  r = b - STEP;
      I_RET, I_POPL:    r = b + STEP;
      default:          r = '0;
    endcase
  end

  assign zf = (r == '0);
  assign sf = r[MSB];

endmodule

// File: rtl/ex_stage.sv
// Registered Y86 execute stage: owns the CC register, resolves JXX/CMOVXX conditions
// against the pre-edge CC, and holds results in an output register behind valid/ready.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STACK_STEP = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     cc_inhibit,
  input  logic     flush,
  dec_ex_if.slave  dec,
  ex_mem_if.master mem
);

  logic [WIDTH-1:0] alu_r;
  logic             alu_zf, alu_sf, alu_of, alu_err;

  ex_alu #(.WIDTH(WIDTH), .STACK_STEP(STACK_STEP)) u_alu (
    .icode (dec.icode_i),
    .ifun  (dec.ifun_i),
    .a     (dec.valA_i),
    .b     (dec.valB_i),
    .c     (dec.valC_i),
    .r     (alu_r),
    .zf    (alu_zf),
    .sf    (alu_sf),
    .of    (alu_of),
    .err   (alu_err)
  );

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] valE_q, valE_d;
  logic [WIDTH-1:0] valA_q, valA_d;
  logic [3:0]       icode_q, icode_d;
  logic [3:0]       dstE_q, dstE_d;
  logic [3:0]       dstM_q, dstM_d;
  logic             cnd_q, cnd_d;
  logic             err_q, err_d;
  cc_t              cc_q, cc_d;

  logic in_ready, accept, is_cond, cnd_now, cc_we;
  logic [3:0] dstE_now;

  assign in_ready     = ~out_valid_q | mem.out_ready;
  assign dec.in_ready = in_ready;
  assign accept       = dec.in_valid & in_ready;

  always_comb begin
    is_cond  = (dec.icode_i == I_JXX) || (dec.icode_i == I_CMOVXX);
    cnd_now  = is_cond & ~alu_err & cond_eval(cc_q, dec.ifun_i);
    // A false CMOVXX and any illegal-ifun instruction must not write a register.
    dstE_now = (alu_err || ((dec.icode_i == I_CMOVXX) && !cnd_now)) ? RNONE : dec.dstE_i;
    cc_we    = accept & ~flush & ~cc_inhibit & (dec.icode_i == I_OPL) & ~alu_err;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    valE_d      = valE_q;
    valA_d      = valA_q;
    icode_d     = icode_q;
    dstE_d      = dstE_q;
    dstM_d      = dstM_q;
    cnd_d       = cnd_q;
    err_d       = err_q;
    cc_d        = cc_q;
    if (accept && flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      valE_d      = alu_r;
      valA_d      = dec.valA_i;
      icode_d     = dec.icode_i;
      dstE_d      = dstE_now;
      dstM_d      = dec.dstM_i;
      cnd_d       = cnd_now;
      err_d       = alu_err;
    end else if (mem.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (cc_we) cc_d = '{zf: alu_zf, sf: alu_sf, of: alu_of};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      valE_q      <= '0;
      valA_q      <= '0;
      icode_q     <= I_NOP;
      dstE_q      <= RNONE;
      dstM_q      <= RNONE;
      cnd_q       <= 1'b0;
      err_q       <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      valE_q      <= valE_d;
      valA_q      <= valA_d;
      icode_q     <= icode_d;
      dstE_q      <= dstE_d;
      dstM_q      <= dstM_d;
      cnd_q       <= cnd_d;
      err_q       <= err_d;
      cc_q        <= cc_d;
    end
  end

  assign mem.out_valid = out_valid_q;
  assign mem.valE_o    = valE_q;
  assign mem.valA_o    = valA_q;
  assign mem.icode_o   = icode_q;
  assign mem.dstE_o    = dstE_q;
  assign mem.dstM_o    = dstM_q;
  assign mem.cnd_o     = cnd_q;
  assign mem.err_o     = err_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table through a scoreboard queue, then hand-written
// reset, stall, flush/inhibit and 16-bit sequences.
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0, cc_inhibit = 1'b0;
  logic flush16 = 1'b0, cc_inhibit16 = 1'b0;

  always #5 clk = ~clk;

  dec_ex_if #(.WIDTH(32)) d32 ();
  ex_mem_if #(.WIDTH(32)) m32 ();
  dec_ex_if #(.WIDTH(16)) d16 ();
  ex_mem_if #(.WIDTH(16)) m16 ();

  ex_stage #(.WIDTH(32), .STACK_STEP(4)) dut (
    .clk(clk), .rst(rst), .cc_inhibit(cc_inhibit), .flush(flush), .dec(d32), .mem(m32));

  ex_stage #(.WIDTH(16), .STACK_STEP(4)) dut16 (
    .clk(clk), .rst(rst), .cc_inhibit(cc_inhibit16), .flush(flush16), .dec(d16), .mem(m16));

  typedef struct {
    logic [3:0]  icode, ifun;
    logic [31:0] a, b, c;
    logic [3:0]  dste, dstm;
    logic [31:0] e_vale;
    logic        e_cnd;
    logic [3:0]  e_dste;
    logic        e_err;
    logic [2:0]  e_cc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic [3:0] ic, input logic [3:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [3:0] de,
                         input logic [3:0] dm);
    d32.in_valid = 1'b1;
    d32.icode_i  = ic;
    d32.ifun_i   = fn;
    d32.valA_i   = a;
    d32.valB_i   = b;
    d32.valC_i   = c;
    d32.dstE_i   = de;
    d32.dstM_i   = dm;
  endtask

  function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] c, input logic [3:0] de,
                              input logic [31:0] ve, input logic cn, input logic [3:0] ede,
                              input logic er, input logic [2:0] cc);
    vec_t v;
    v.icode = ic; v.ifun = fn; v.a = a; v.b = b; v.c = c; v.dste = de; v.dstm = 4'h7;
    v.e_vale = ve; v.e_cnd = cn; v.e_dste = ede; v.e_err = er; v.e_cc = cc;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [31:0] last_vale;

    d32.in_valid = 1'b0; d32.icode_i = 4'h1; d32.ifun_i = 4'h0; d32.valA_i = '0;
    d32.valB_i = '0; d32.valC_i = '0; d32.dstE_i = 4'hF; d32.dstM_i = 4'hF;
    m32.out_ready = 1'b1;
    d16.in_valid = 1'b0; d16.icode_i = 4'h1; d16.ifun_i = 4'h0; d16.valA_i = '0;
    d16.valB_i = '0; d16.valC_i = '0; d16.dstE_i = 4'hF; d16.dstM_i = 4'hF;
    m16.out_ready = 1'b1;

    // icode ifun valA valB valC dstE | valE cnd dstE err CC{Z,S,O}
    vecs.push_back(mk(4'h7, 4'h3, 32'h0, 32'h0, 32'h40, 4'hF, 32'h0, 1, 4'hF, 0, 3'b100));
    vecs.push_back(mk(4'h7, 4'h2, 32'h0, 32'h0, 32'h40, 4'hF, 32'h0, 0, 4'hF, 0, 3'b100));
    vecs.push_back(mk(4'h2, 4'h1, 32'h55, 32'h0, 32'h0, 4'h3, 32'h55, 1, 4'h3, 0, 3'b100));
    vecs.push_back(mk(4'h2, 4'h6, 32'h55, 32'h0, 32'h0, 4'h3, 32'h55, 0, 4'hF, 0, 3'b100));
    vecs.push_back(mk(4'h6, 4'h1, 32'h1, 32'h80000000, 32'h0, 4'h2, 32'h7FFFFFFF, 0, 4'h2, 0, 3'b001));
    vecs.push_back(mk(4'h7, 4'h2, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0, 1, 4'hF, 0, 3'b001));
    vecs.push_back(mk(4'h7, 4'h5, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0, 0, 4'hF, 0, 3'b001));
    vecs.push_back(mk(4'h6, 4'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 4'h2, 32'h80000000, 0, 4'h2, 0, 3'b011));
    vecs.push_back(mk(4'h7, 4'h5, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0, 1, 4'hF, 0, 3'b011));
    vecs.push_back(mk(4'h7, 4'h1, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0, 0, 4'hF, 0, 3'b011));
    vecs.push_back(mk(4'h6, 4'h2, 32'hF0, 32'h0F, 32'h0, 4'h2, 32'h0, 0, 4'h2, 0, 3'b100));
    vecs.push_back(mk(4'h2, 4'h3, 32'h77, 32'h0, 32'h0, 4'h4, 32'h77, 1, 4'h4, 0, 3'b100));
    vecs.push_back(mk(4'h6, 4'h3, 32'hFFFFFFFF, 32'h0, 32'h0, 4'h2, 32'hFFFFFFFF, 0, 4'h2, 0, 3'b010));
    vecs.push_back(mk(4'h7, 4'h4, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0, 1, 4'hF, 0, 3'b010));
    vecs.push_back(mk(4'h7, 4'h6, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0, 0, 4'hF, 0, 3'b010));
    vecs.push_back(mk(4'h3, 4'h0, 32'h0, 32'h0, 32'h1234, 4'h5, 32'h1234, 0, 4'h5, 0, 3'b010));
    vecs.push_back(mk(4'h4, 4'h0, 32'h9, 32'h100, 32'h8, 4'hF, 32'h108, 0, 4'hF, 0, 3'b010));
    vecs.push_back(mk(4'h5, 4'h0, 32'h0, 32'h100, 32'h8, 4'hF, 32'h108, 0, 4'hF, 0, 3'b010));
    vecs.push_back(mk(4'hA, 4'h0, 32'h0, 32'h100, 32'h0, 4'h4, 32'hFC, 0, 4'h4, 0, 3'b010));
    vecs.push_back(mk(4'h8, 4'h0, 32'h0, 32'h100, 32'h0, 4'h4, 32'hFC, 0, 4'h4, 0, 3'b010));
    vecs.push_back(mk(4'hB, 4'h0, 32'h0, 32'h100, 32'h0, 4'h4, 32'h104, 0, 4'h4, 0, 3'b010));
    vecs.push_back(mk(4'h9, 4'h0, 32'h0, 32'h100, 32'h0, 4'h4, 32'h104, 0, 4'h4, 0, 3'b010));
    vecs.push_back(mk(4'h6, 4'h7, 32'h1, 32'h1, 32'h0, 4'h2, 32'h0, 0, 4'hF, 1, 3'b010));
    vecs.push_back(mk(4'h7, 4'h7, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0, 0, 4'hF, 1, 3'b010));
    vecs.push_back(mk(4'h2, 4'h9, 32'h55, 32'h0, 32'h0, 4'h3, 32'h0, 0, 4'hF, 1, 3'b010));
    vecs.push_back(mk(4'h7, 4'h2, 32'h0, 32'h0, 32'h0, 4'hF, 32'h0, 1, 4'hF, 0, 3'b010));
    vecs.push_back(mk(4'h0, 4'h0, 32'h3, 32'h4, 32'h5, 4'hF, 32'h0, 0, 4'hF, 0, 3'b010));
    vecs.push_back(mk(4'hC, 4'h0, 32'h3, 32'h5, 32'h5, 4'h2, 32'h0, 0, 4'h2, 0, 3'b010));
    vecs.push_back(mk(4'h6, 4'h0, 32'h1, 32'hFFFFFFFF, 32'h0, 4'h2, 32'h0, 0, 4'h2, 0, 3'b100));
    vecs.push_back(mk(4'h6, 4'h1, 32'h5, 32'h3, 32'h0, 4'h2, 32'hFFFFFFFE, 0, 4'h2, 0, 3'b010));
    vecs.push_back(mk(4'h6, 4'h1, 32'h80000000, 32'h0, 32'h0, 4'h2, 32'h80000000, 0, 4'h2, 0, 3'b011));

    // Reset
    step(); step();
    chk("rst.out_valid", 32'(m32.out_valid), 32'h0);
    chk("rst.dstE", 32'(m32.dstE_o), 32'hF);
    chk("rst.icode", 32'(m32.icode_o), 32'h1);
    chk("rst.valE", m32.valE_o, 32'h0);
    chk("rst.cc", 32'(dut.cc_q), 32'h4);
    rst = 1'b1;
    step();
    chk("rst.in_ready", 32'(d32.in_ready), 32'h1);

    // Vector table, back to back
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive32(v.icode, v.ifun, v.a, v.b, v.c, v.dste, v.dstm);
      exp_q.push_back(v);
      step();
      chk($sformatf("v%0d.out_valid", i), 32'(m32.out_valid), 32'h1);
      if (m32.out_valid && exp_q.size() > 0) begin
        v = exp_q.pop_front();
        chk($sformatf("v%0d.valE", i), m32.valE_o, v.e_vale);
        chk($sformatf("v%0d.cnd", i), 32'(m32.cnd_o), 32'(v.e_cnd));
        chk($sformatf("v%0d.dstE", i), 32'(m32.dstE_o), 32'(v.e_dste));
        chk($sformatf("v%0d.err", i), 32'(m32.err_o), 32'(v.e_err));
        chk($sformatf("v%0d.icode", i), 32'(m32.icode_o), 32'(v.icode));
        chk($sformatf("v%0d.valA", i), m32.valA_o, v.a);
        chk($sformatf("v%0d.dstM", i), 32'(m32.dstM_o), 32'(v.dstm));
        chk($sformatf("v%0d.cc", i), 32'(dut.cc_q), 32'(v.e_cc));
      end
    end
    last_vale = 32'h80000000;
    d32.in_valid = 1'b0;
    step();
    chk("idle.out_valid", 32'(m32.out_valid), 32'h0);
    chk("idle.valE_hold", m32.valE_o, last_vale);

    // Stall: second OPL held off while out_ready is low
    drive32(4'h6, 4'h0, 32'h1, 32'h1, 32'h0, 4'h2, 4'hF);
    step();
    chk("stall.pre_valE", m32.valE_o, 32'h2);
    chk("stall.pre_cc", 32'(dut.cc_q), 32'h0);
    drive32(4'h6, 4'h1, 32'h5, 32'h5, 32'h0, 4'h3, 4'hF);
    m32.out_ready = 1'b0;
    #1;
    chk("stall.in_ready", 32'(d32.in_ready), 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall.out_valid", 32'(m32.out_valid), 32'h1);
      chk("stall.valE", m32.valE_o, 32'h2);
      chk("stall.dstE", 32'(m32.dstE_o), 32'h2);
      chk("stall.cc", 32'(dut.cc_q), 32'h0);
    end
    m32.out_ready = 1'b1;
    #1;
    chk("stall.in_ready_rel", 32'(d32.in_ready), 32'h1);
    step();
    chk("stall.post_valE", m32.valE_o, 32'h0);
    chk("stall.post_dstE", 32'(m32.dstE_o), 32'h3);
    chk("stall.post_cc", 32'(dut.cc_q), 32'h4);

    // Flush and cc_inhibit
    drive32(4'h6, 4'h0, 32'h1, 32'h1, 32'h0, 4'h2, 4'hF);
    step();
    chk("fl.pre_cc", 32'(dut.cc_q), 32'h0);
    drive32(4'h6, 4'h0, 32'h1, 32'hFFFFFFFF, 32'h0, 4'h2, 4'hF);
    flush = 1'b1;
    step();
    chk("fl.out_valid", 32'(m32.out_valid), 32'h0);
    chk("fl.cc", 32'(dut.cc_q), 32'h0);
    flush = 1'b0;
    cc_inhibit = 1'b1;
    step();
    chk("inh.out_valid", 32'(m32.out_valid), 32'h1);
    chk("inh.valE", m32.valE_o, 32'h0);
    chk("inh.cc", 32'(dut.cc_q), 32'h0);
    cc_inhibit = 1'b0;
    d32.in_valid = 1'b0;
    m32.out_ready = 1'b0;
    flush = 1'b1;
    step();
    chk("fl_stall.out_valid", 32'(m32.out_valid), 32'h1);
    m32.out_ready = 1'b1;
    step();
    chk("fl_drain.out_valid", 32'(m32.out_valid), 32'h0);
    flush = 1'b0;

    // 16-bit datapath
    d16.in_valid = 1'b1; d16.icode_i = 4'hA; d16.ifun_i = 4'h0; d16.valB_i = 16'h0;
    d16.dstE_i = 4'h4;
    step();
    chk("w16.push_valE", 32'(m16.valE_o), 32'hFFFC);
    d16.icode_i = 4'h6; d16.ifun_i = 4'h7; d16.valA_i = 16'h1; d16.valB_i = 16'h1;
    step();
    chk("w16.err", 32'(m16.err_o), 32'h1);
    chk("w16.err_valE", 32'(m16.valE_o), 32'h0);
    d16.ifun_i = 4'h1; d16.valA_i = 16'h1; d16.valB_i = 16'h8000;
    step();
    chk("w16.sub_valE", 32'(m16.valE_o), 32'h7FFF);
    chk("w16.sub_cc", 32'(dut16.cc_q), 32'h1);
    d16.in_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
